// File: rtl/cdc_handshake_tx_if.sv
// Bundle of the upstream valid/ready port and the 4-phase req/ack crossing signals.
// slave is the transmitter's view and master is the driver/responder's view.
interface cdc_handshake_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] data_out;
    logic              req_out;
    logic              ack_in;
    logic              done;
    logic              err;
    logic              err_clr;

    modport slave (
        input  in_valid, in_data, ack_in, err_clr,
        output in_ready, data_out, req_out, done, err
    );

    modport master (
        output in_valid, in_data, ack_in, err_clr,
        input  in_ready, data_out, req_out, done, err
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing for one DATA_W-bit word.
// Optional per-wait-state timeout is enabled with macro CDC_TX_TIMEOUT_EN.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module cdc_handshake_tx #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_sync,
    input  logic                      rst_n,
    cdc_handshake_tx_if.slave         bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              req_q, req_nxt;
    logic              done_q, done_nxt;
    logic              ack_s;
    logic              in_ready;

    sync_2ff #(.RESET_VAL(1'b0)) u_ack_sync (
        .clk   (clk_sync),
        .rst_n (rst_n),
        .d     (bus.ack_in),
        .q     (ack_s)
    );

    // A still-high remote ack means the previous handshake has not closed yet.
    assign in_ready = (state == IDLE) && !ack_s;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q, err_nxt;
    logic             abort_q, abort_nxt;
    logic             cnt_hit;

    assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = bus.err_clr & (TIMEOUT_CYCLES > 1);
`endif

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        req_nxt   = req_q;
        done_nxt  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        // Timeout beats err_clr because the set is applied after the clear.
        err_nxt   = err_q & ~bus.err_clr;
        abort_nxt = abort_q;
        cnt_nxt   = (state == IDLE) ? '0 : cnt_q + 1'b1;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    data_nxt  = bus.in_data;
                    req_nxt   = 1'b1;
                    state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = REQ_LO;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (cnt_hit) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = REQ_LO;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                    // An abandoned request is not a completed transfer.
                    done_nxt  = !abort_q;
                    abort_nxt = 1'b0;
`else
                    done_nxt  = 1'b1;
`endif
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (cnt_hit) begin
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b0;
                    state_nxt = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
`ifdef CDC_TX_TIMEOUT_EN
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk_sync or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            req_q  <= req_nxt;
            done_q <= done_nxt;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    always_ff @(posedge clk_sync or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            abort_q <= abort_nxt;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready = in_ready;
    assign bus.data_out = data_q;
    assign bus.req_out  = req_q;
    assign bus.done     = done_q;
endmodule
